dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Single-port controller and arbiter in front of the four byte-wide data-memory banks (bank i holds byte lane i).
- Shares the banks between the CPU load/store unit and the image-coprocessor DMA port.
- For each access it generates per-bank addresses and enables, and aligns store data.
- Returns read data to the owning requester one cycle later, with byte/halfword extraction and sign extension.

Parameters:
- ADDRW, 13, bank address width; word-address bits used are addr[ADDRW+1:2].
- STARVE_LIMIT, 4, consecutive cycles the coprocessor may be refused before it takes priority; must be >= 1.

Ports:
- clk  in  1  global clock, posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  CPU byte address.
- cpu_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- cpu_unsigned  in  1  load zero-extends when 1.
- cpu_wdata  in  32  store data, right-justified.
- cpu_gnt  out  1  request accepted this cycle.
- cpu_misalign  out  1  accepted request was misaligned or illegal; it is dropped.
- cpu_rvalid  out  1  load data valid.
- cpu_rdata  out  32  extended load data.
- cp_req  in  1  coprocessor word request.
- cp_we  in  1  store/load select.
- cp_addr  in  32  byte address, word-aligned; bits [1:0] are ignored.
- cp_wdata  in  32  store word.
- cp_gnt  out  1  request accepted.
- cp_rvalid  out  1  load data valid.
- cp_rdata  out  32  load word.
- bank_addr  out  ADDRW  shared bank address.
- bank_rden  out  4  per-bank read enable.
- bank_wen  out  4  per-bank write enable.
- bank_wdata  out  32  byte i drives bank i.
- bank_rdata  in  32  byte i from bank i; banks update it on negedge.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: cpu_rvalid = 0, cp_rvalid = 0, cpu_rdata = 0, cp_rdata = 0, starvation counter = 0, response registers cleared.
- Combinational outputs:
  - gnt, misalign and the bank_* signals are combinational from the current requests and the counter.
  - With no grant: bank_rden = bank_wen = 0, and bank_addr/bank_wdata hold their default value 0.
- Arbitration, evaluated each cycle:
  - If starve_cnt == STARVE_LIMIT and cp_req, the coprocessor wins.
  - Otherwise cpu_req wins, else cp_req wins.
  - At most one gnt per cycle.
- Starvation counter:
  - Increments when cp_req && !cp_gnt, saturating at STARVE_LIMIT.
  - Clears when cp_gnt is asserted or cp_req is low.
- Handshake:
  - A transfer occurs at the posedge where req && gnt.
  - A requester holds req and its fields stable until granted.
  - Back-to-back grants are allowed every cycle.
- CPU alignment, off = cpu_addr[1:0]:
  - Byte: any off is legal.
  - Half: off must be 0 or 2.
  - Word: off must be 0.
  - A misaligned or illegal CPU access is still granted and cpu_misalign pulses with cpu_gnt, but it issues no bank enables and produces no rvalid.
- Store lane mapping:
  - Byte: wen = 0001 << off, with wdata byte replicated to all lanes.
  - Half: wen = 0011 << off, with halfword replicated to both halves.
  - Word: wen = 1111.
  - Coprocessor stores always use 1111.
  - The banks write at the negedge of the grant cycle.
- Loads:
  - bank_rden uses the same lane mask as a store would.
  - The banks capture data at the negedge of grant cycle N.
  - At posedge N+1 the block registers the formatted data, so rvalid is high for exactly cycle N+1 (latency 1) on the owning port only.
  - A response owner/size/off/unsigned register is written at grant.
- Load formatting:
  - Byte: lane off, sign- or zero-extended.
  - Half: lanes off..off+1, extended.
  - Word: raw data.
  - cp_rdata is always the raw word.
- Stores produce no rvalid.
- Address mapping: bank_addr = addr[ADDRW+1:2]; higher address bits are ignored (wrap).
- Simultaneous events:
  - A response in cycle N+1 and a new grant in cycle N+1 are independent; the pipeline is one stage deep, so no stall is needed.
- Reset mid-operation: any pending response is dropped, with no rvalid after reset release.

Decomposition:
- Shared package dmem_pkg:
  - typedef mem_size_t: BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10.
  - typedef req_owner_t: OWN_CPU, OWN_CP.
  - Constant NUM_BANKS = 4.
- One natural sub-module, dmem_lane_fmt, holding:
  - lane mask and store-replication logic;
  - load extract/extend logic.

Test Plan:
- CPU word store 0xDEADBEEF at 0x100, then word load at 0x100 -> wen = 1111, bank_addr = 0x40; next load gives cpu_rvalid one cycle after gnt with cpu_rdata = 0xDEADBEEF.
- CPU byte load at 0x103, data 0xDEADBEEF, signed -> 0xFFFFFFDE; same access unsigned -> 0x000000DE; half load at 0x102, signed -> 0xFFFFDEAD.
- CPU half store 0x1234 at 0x101 -> cpu_gnt = 1, cpu_misalign = 1, bank_wen = 0000, no rvalid; memory at 0x100 unchanged.
- cpu_req and cp_req held high continuously, STARVE_LIMIT = 4 -> CPU granted 4 cycles, CP granted in the 5th cycle, then the pattern repeats.
- CPU load granted in cycle N and CP load granted in cycle N+1 -> cpu_rvalid only in N+1, cp_rvalid only in N+2, data routed to the correct ports.
- Load granted, then rst_n asserted low before the next posedge -> after release, cpu_rvalid stays 0 and all outputs are at reset values.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_pkg;

  localparam int NUM_BANKS = 4;

  // Access size as encoded on the CPU port; 2'b11 has no enumerator and is illegal.
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_CP  = 1'b1
  } req_owner_t;

  // Response tracking for the single-stage read return path.
  typedef struct packed {
    logic       valid;
    req_owner_t owner;
  } rsp_t;

  // True when the byte offset is legal for the given access size.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      BYTE:    return 1'b1;
      HALF:    return ~off[0];
      WORD:    return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and bank signals of the data-memory arbiter.
// slave = arbiter view, master = requester/bank view.
interface dmem_arbiter_if #(
  parameter int ADDRW = 13
);

  // CPU load/store unit
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_misalign;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  // Coprocessor DMA port
  logic        cp_req;
  logic        cp_we;
  logic [31:0] cp_addr;
  logic [31:0] cp_wdata;
  logic        cp_gnt;
  logic        cp_rvalid;
  logic [31:0] cp_rdata;

  // Byte-lane banks
  logic [ADDRW-1:0] bank_addr;
  logic [3:0]       bank_rden;
  logic [3:0]       bank_wen;
  logic [31:0]      bank_wdata;
  logic [31:0]      bank_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_size, cpu_unsigned, cpu_wdata,
    output cpu_gnt, cpu_misalign, cpu_rvalid, cpu_rdata,
    input  cp_req, cp_we, cp_addr, cp_wdata,
    output cp_gnt, cp_rvalid, cp_rdata,
    output bank_addr, bank_rden, bank_wen, bank_wdata,
    input  bank_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_size, cpu_unsigned, cpu_wdata,
    input  cpu_gnt, cpu_misalign, cpu_rvalid, cpu_rdata,
    output cp_req, cp_we, cp_addr, cp_wdata,
    input  cp_gnt, cp_rvalid, cp_rdata,
    input  bank_addr, bank_rden, bank_wen, bank_wdata,
    output bank_rdata
  );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane helper: lane mask and store replication on the way in,
// lane extraction and sign/zero extension on the way out.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_legal,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  // Lane mask and replicated store data; an illegal access enables no lane.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    o_legal = is_aligned(i_size, i_off);
    o_mask  = 4'b0000;
    o_wdata = '0;
    if (o_legal) begin
      case (i_size)
        BYTE: begin
          o_mask  = 4'b0001 << i_off;
          o_wdata = {4{i_wdata[7:0]}};
        end
        HALF: begin
          o_mask  = 4'b0011 << i_off;
          o_wdata = {2{i_wdata[15:0]}};
        end
        default: begin
          o_mask  = 4'b1111;
          o_wdata = i_wdata;
        end
      endcase
    end
  end

  // Bring the addressed lane(s) down to bit 0 and extend to 32 bits.
  always_comb begin
    w_shifted = i_rdata >> {i_off, 3'b000};
    case (i_size)
      BYTE:    o_rdata = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      HALF:    o_rdata = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter and controller sharing four byte-lane data-memory banks between
// the CPU load/store unit and the coprocessor DMA port. Bank controls are
// combinational from the winning request; load data returns one cycle later.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDRW        = 13,
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam int                CNTW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNTW-1:0]   LIMIT = CNTW'(STARVE_LIMIT);

  logic [CNTW-1:0]  r_starve;
  rsp_t             r_rsp;
  logic [31:0]      r_cpu_rdata;
  logic [31:0]      r_cp_rdata;

  logic             w_cp_pri;
  logic             w_cpu_gnt;
  logic             w_cp_gnt;
  logic             w_grant;
  logic             w_we;
  logic [1:0]       w_size;
  logic [1:0]       w_off;
  logic             w_unsigned;
  logic [ADDRW-1:0] w_word_addr;
  logic [31:0]      w_wdata_in;
  logic             w_legal;
  logic [3:0]       w_mask;
  logic [31:0]      w_wdata;
  logic [31:0]      w_fmt;
  logic             w_load_go;

  // Pick the winner: a starved coprocessor first, then the CPU, then the coprocessor.
  always_comb begin
    w_cp_pri  = (r_starve == LIMIT) && bus.cp_req;
    w_cpu_gnt = bus.cpu_req && !w_cp_pri;
    w_cp_gnt  = bus.cp_req && !w_cpu_gnt;
    w_grant   = w_cpu_gnt || w_cp_gnt;
  end

  // Steer the winning request's fields; the coprocessor always moves whole words.
  always_comb begin
    if (w_cp_gnt) begin
      w_we        = bus.cp_we;
      w_size      = WORD;
      w_off       = 2'b00;
      w_unsigned  = 1'b0;
      w_word_addr = bus.cp_addr[ADDRW+1:2];
      w_wdata_in  = bus.cp_wdata;
    end else begin
      w_we        = bus.cpu_we;
      w_size      = bus.cpu_size;
      w_off       = bus.cpu_addr[1:0];
      w_unsigned  = bus.cpu_unsigned;
      w_word_addr = bus.cpu_addr[ADDRW+1:2];
      w_wdata_in  = bus.cpu_wdata;
    end
  end

  // Lane mapping for the store/read enables and formatting of the returning word.
  dmem_lane_fmt u_lane_fmt (
    .i_size     (w_size),
    .i_off      (w_off),
    .i_unsigned (w_unsigned),
    .i_wdata    (w_wdata_in),
    .i_rdata    (bus.bank_rdata),
    .o_legal    (w_legal),
    .o_mask     (w_mask),
    .o_wdata    (w_wdata),
    .o_rdata    (w_fmt)
  );

  // Drive the banks only for a granted access; everything idles at 0 otherwise.
  always_comb begin
    bus.bank_addr  = '0;
    bus.bank_rden  = 4'b0000;
    bus.bank_wen   = 4'b0000;
    bus.bank_wdata = '0;
    if (w_grant) begin
      bus.bank_addr = w_word_addr;
      if (w_we) begin
        bus.bank_wen   = w_mask;
        bus.bank_wdata = w_wdata;
      end else begin
        bus.bank_rden = w_mask;
      end
    end
  end

  // Handshake outputs and return path.
  always_comb begin
    bus.cpu_gnt      = w_cpu_gnt;
    bus.cp_gnt       = w_cp_gnt;
    bus.cpu_misalign = w_cpu_gnt && !w_legal;
    w_load_go        = w_grant && !w_we && w_legal;
    bus.cpu_rvalid   = r_rsp.valid && (r_rsp.owner == OWN_CPU);
    bus.cp_rvalid    = r_rsp.valid && (r_rsp.owner == OWN_CP);
    bus.cpu_rdata    = r_cpu_rdata;
    bus.cp_rdata     = r_cp_rdata;
  end

  // Count consecutive refused coprocessor cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!bus.cp_req || w_cp_gnt) begin
      r_starve <= '0;
    end else if (r_starve != LIMIT) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Capture formatted load data at the end of the grant cycle; rvalid lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp       <= '0;
      r_cpu_rdata <= '0;
      r_cp_rdata  <= '0;
    end else begin
      r_rsp.valid <= w_load_go;
      r_rsp.owner <= w_cp_gnt ? OWN_CP : OWN_CPU;
      if (w_load_go && !w_cp_gnt) r_cpu_rdata <= w_fmt;
      if (w_load_go && w_cp_gnt)  r_cp_rdata  <= w_fmt;
    end
  end

endmodule
